param_rr_scheduler: RTL
=======================

Name: param_rr_scheduler

Overview:
- Shares one parameterized hold/delay register stage (WIDTH data bits, fixed LATENCY) between NREQ requesters.
- Arbitrates requesters round-robin, captures the winner's data, counts out LATENCY cycles, then presents the result on Q with a one-cycle valid strobe and the winner's index.
- Sits between multiple producers and the single shared data-register resource; all sizing is by parameter override at instantiation.

Parameters:
- WIDTH, 8: data width per requester and of Q.
- NREQ, 4: number of requesters; must be >= 2.
- LATENCY, 3: cycles from grant to result; must be >= 1.
- IDW, $clog2(NREQ): width of the requester index output; derived, not overridden.

Ports:
- Clk  in  1: single clock; all logic on the rising edge.
- Rst  in  1: reset, asynchronous, active-high.
- Req  in  NREQ: level request, bit i = requester i.
- D  in  NREQ*WIDTH: packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- Gnt  out  NREQ: one-hot grant, all-zero when idle.
- Busy  out  1: high while a transaction is in flight.
- Q  out  WIDTH: result register.
- QValid  out  1: one-cycle strobe, Q/QId new this cycle.
- QId  out  IDW: index of the requester whose data is on Q.

Behaviour:
- Reset (asynchronous assert, takes effect immediately): Gnt=0, Busy=0, Q=0, QValid=0, QId=0, state=IDLE, counter=0, round-robin pointer=0.
- Reset mid-transaction discards the transaction; no QValid is produced for it.
- States: IDLE, BUSY.
- IDLE, Req==0: stay; Gnt=0, Busy=0.
- IDLE, Req!=0, at edge k:
  - Winner = first set Req bit searching circularly from the pointer.
  - Gnt=onehot(winner); Busy=1.
  - Internal hold register <= D slice of the winner.
  - Winner index latched for QId.
  - counter <= LATENCY-1; pointer <= (winner+1) mod NREQ; go to BUSY.
- BUSY, counter!=0: decrement; Gnt, Busy and the hold register are stable.
- BUSY, counter==0 (edge k+LATENCY):
  - Q <= hold; QId <= winner; QValid=1 for exactly this one cycle.
  - Gnt=0, Busy=0; go to IDLE.
- Latency: Req sampled at edge k gives QValid high during the cycle after edge k+LATENCY.
- Throughput: the earliest next grant is at edge k+LATENCY+1, so there is one IDLE cycle between transactions.
- Req or D changes during BUSY are ignored. The captured data is used, and the grant is not revoked.
- Req is level-sensitive: a requester still asserting Req after its QValid is re-arbitrated. Round-robin guarantees every other pending requester is served first.
- Q and QId hold their last values until the next completion. QValid=0 otherwise.
- Pointer wraps: after NREQ-1 wins, the pointer returns to 0.
- NREQ<2 or LATENCY<1 must raise an elaboration/simulation error.

Test Plan:
- Reset check: assert Rst for 2 cycles with Req=4'b1111 -> Gnt=0, Busy=0, Q=0, QValid=0, QId=0 throughout; release -> grant to requester 0 at the first edge.
- Single request: WIDTH=8, LATENCY=3, Req=4'b0100, D slice2=8'hA5, sampled edge 10 -> Gnt=4'b0100 from edge 10; edge 13: Q=8'hA5, QId=2, QValid high one cycle; Gnt=0 after.
- Round-robin fairness: Req=4'b1111 held constant -> grant order 0,1,2,3,0. Grants at edges 1,5,9,13,17 (LATENCY=3, one idle gap each).
- Data capture isolation: change D slice1 from 8'h11 to 8'hFF one cycle after grant to requester 1 -> Q=8'h11 at completion.
- Reset mid-operation: Rst pulse at edge k+1 of a LATENCY=3 transaction -> outputs return to reset values immediately, no QValid, pointer=0.
- Override: instantiate with #(16, 2, 1) and alternate Req=2'b11 -> QValid on alternating requesters every 2 cycles, 16-bit Q correct, QId 0/1 alternating.

Source files
------------

// File: rtl/param_rr_scheduler.sv
// rtl/param_rr_scheduler.sv - round-robin arbiter sharing one fixed-latency hold register stage
module param_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] D,
  output logic [NREQ-1:0]       Gnt,
  output logic                  Busy,
  output logic [WIDTH-1:0]      Q,
  output logic                  QValid,
  output logic [IDW-1:0]        QId
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (NREQ < 2) begin : g_bad_nreq
    $error("param_rr_scheduler: NREQ must be >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("param_rr_scheduler: LATENCY must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   qid_q, qid_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             qvalid_q, qvalid_d;

  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             found;

  // Circular priority search starting at the pointer; first hit wins.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && Req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    q_d      = q_q;
    qid_d    = qid_q;
    qvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          win_d   = pick;
          hold_d  = D[int'(pick)*WIDTH +: WIDTH];
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          cnt_d   = CW'(LATENCY - 1);
          ptr_d   = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          q_d      = hold_q;
          qid_d    = win_q;
          qvalid_d = 1'b1;
          gnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      q_q      <= '0;
      qid_q    <= '0;
      qvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      q_q      <= q_d;
      qid_q    <= qid_d;
      qvalid_q <= qvalid_d;
    end
  end

  assign Gnt    = gnt_q;
  assign Busy   = (state_q == BUSY);
  assign Q      = q_q;
  assign QValid = qvalid_q;
  assign QId    = qid_q;

endmodule
